// File: rtl/uart_buf_pkg.sv
// ============================================================================
// Module      : uart_buf_pkg
// Description : Shared types and helpers for the UART receive buffer arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_buf_pkg;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    READ      = 2'd2,
    READ_DATA = 2'd3
  } state_t;

  // Which side received the most recent RAM grant.
  typedef enum logic {
    GR_WR = 1'b0,
    GR_RD = 1'b1
  } grant_t;

  // Round-robin pick between eligible requesters; only meaningful when at
  // least one side is eligible. On a tie the side not served last wins.
  function automatic grant_t rr_pick(input grant_t last_grant,
                                     input logic   wr_elig,
                                     input logic   rd_elig);
    grant_t pick;
    if (wr_elig && rd_elig) begin
      pick = (last_grant == GR_RD) ? GR_WR : GR_RD;
    end else if (wr_elig) begin
      pick = GR_WR;
    end else begin
      pick = GR_RD;
    end
    return pick;
  endfunction

endpackage

`default_nettype wire

// File: rtl/buf_ptr_counter.sv
// ============================================================================
// Module      : buf_ptr_counter
// Description : Buffer address pointer; advances on inc and wraps from
//               MAX_ADDRESS back to zero, even when the depth is not a
//               power of two.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module buf_ptr_counter
  import uart_buf_pkg::*;
#(
  parameter int N           = 2,
  parameter int MAX_ADDRESS = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [N-1:0] ptr
);

  localparam logic [N-1:0] c_last = N'(MAX_ADDRESS);

  // Pointer register with explicit wrap at the last valid address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == c_last) ? '0 : ptr + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_buffer_arbiter.sv
// ============================================================================
// Module      : uart_buffer_arbiter
// Description : Shares one single-port synchronous RAM between the UART RX
//               writer and the downstream reader. Owns the wrapping read and
//               write pointers, round-robin arbitration, occupancy count and
//               full/empty flags. All outputs are registered.
//               Optional feature macro: UART_BUF_ERR_FLAGS_EN adds err_clr,
//               ovf and udf (sticky overflow/underflow attempt flags).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_buffer_arbiter
  import uart_buf_pkg::*;
#(
  parameter int N           = 2,
  parameter int MAX_ADDRESS = 3,
  parameter int W           = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_req,
  input  logic [W-1:0] wr_data,
  output logic         wr_ack,
  input  logic         rd_req,
  output logic [W-1:0] rd_data,
  output logic         rd_valid,
  output logic [N-1:0] ram_addr,
  output logic         ram_we,
  output logic [W-1:0] ram_wdata,
  input  logic [W-1:0] ram_rdata,
  output logic         full,
  output logic         empty,
  output logic [N:0]   count
`ifdef UART_BUF_ERR_FLAGS_EN
  ,
  input  logic         err_clr,
  output logic         ovf,
  output logic         udf
`endif
);

  localparam logic [N:0] c_depth = (N+1)'(MAX_ADDRESS + 1);

  state_t         r_state;
  state_t         w_state_nx;
  grant_t         r_last_grant;
  grant_t         w_last_nx;
  logic [N-1:0]   w_wr_ptr;
  logic [N-1:0]   w_rd_ptr;
  logic           w_wr_inc;
  logic           w_rd_inc;
  logic           w_wr_elig;
  logic           w_rd_elig;
  logic           w_wr_ack_nx;
  logic           w_rd_valid_nx;
  logic           w_ram_we_nx;
  logic [N-1:0]   w_ram_addr_nx;
  logic [W-1:0]   w_ram_wdata_nx;
  logic [W-1:0]   w_rd_data_nx;
  logic [N:0]     w_count_nx;

  buf_ptr_counter #(.N(N), .MAX_ADDRESS(MAX_ADDRESS)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (w_wr_inc),
    .ptr (w_wr_ptr)
  );

  buf_ptr_counter #(.N(N), .MAX_ADDRESS(MAX_ADDRESS)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (w_rd_inc),
    .ptr (w_rd_ptr)
  );

  assign w_wr_elig = wr_req && !full;
  assign w_rd_elig = rd_req && !empty;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state and next-output decode; outputs are registered below.
  always_comb begin
    w_state_nx     = r_state;
    w_last_nx      = r_last_grant;
    w_wr_ack_nx    = 1'b0;
    w_rd_valid_nx  = 1'b0;
    w_ram_we_nx    = 1'b0;
    w_ram_addr_nx  = ram_addr;
    w_ram_wdata_nx = ram_wdata;
    w_rd_data_nx   = rd_data;
    w_count_nx     = count;
    w_wr_inc       = 1'b0;
    w_rd_inc       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_wr_elig || w_rd_elig) begin
          if (rr_pick(r_last_grant, w_wr_elig, w_rd_elig) == GR_WR) begin
            w_state_nx     = WRITE;
            w_last_nx      = GR_WR;
            w_ram_we_nx    = 1'b1;
            w_ram_addr_nx  = w_wr_ptr;
            w_ram_wdata_nx = wr_data;
          end else begin
            w_state_nx    = READ;
            w_last_nx     = GR_RD;
            w_ram_addr_nx = w_rd_ptr;
          end
        end
      end
      WRITE: begin
        // RAM commits at the end of this cycle; ack and count follow it.
        w_wr_ack_nx = 1'b1;
        w_wr_inc    = 1'b1;
        w_count_nx  = count + 1'b1;
        w_state_nx  = IDLE;
      end
      READ: begin
        // Address is on the RAM; data appears one cycle later.
        w_state_nx = READ_DATA;
      end
      READ_DATA: begin
        w_rd_data_nx  = ram_rdata;
        w_rd_valid_nx = 1'b1;
        w_rd_inc      = 1'b1;
        w_count_nx    = count - 1'b1;
        w_state_nx    = IDLE;
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  // Registered outputs, grant history and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= GR_RD;
      wr_ack       <= 1'b0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
    end else begin
      r_last_grant <= w_last_nx;
      wr_ack       <= w_wr_ack_nx;
      rd_valid     <= w_rd_valid_nx;
      rd_data      <= w_rd_data_nx;
      ram_we       <= w_ram_we_nx;
      ram_addr     <= w_ram_addr_nx;
      ram_wdata    <= w_ram_wdata_nx;
      count        <= w_count_nx;
      full         <= (w_count_nx == c_depth);
      empty        <= (w_count_nx == '0);
    end
  end

`ifdef UART_BUF_ERR_FLAGS_EN
  // Sticky flags for requests refused in IDLE; clear beats a same-cycle set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (err_clr) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (r_state == IDLE) begin
      if (wr_req && full) begin
        ovf <= 1'b1;
      end
      if (rd_req && empty) begin
        udf <= 1'b1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_buffer_arbiter.sv
// ============================================================================
// Module      : tb_uart_buffer_arbiter
// Description : Self-checking bench for uart_buffer_arbiter with a behavioural
//               1-cycle RAM and a queue-based transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_buffer_arbiter;

  localparam int N           = 2;
  localparam int MAX_ADDRESS = 3;
  localparam int W           = 8;
  localparam int D           = MAX_ADDRESS + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_req, rd_req, err_clr;
  logic [W-1:0] wr_data;
  logic         wr_ack, rd_valid, ram_we, full, empty;
  logic [W-1:0] rd_data, ram_wdata, ram_rdata;
  logic [N-1:0] ram_addr;
  logic [N:0]   count;
`ifdef UART_BUF_ERR_FLAGS_EN
  logic         ovf, udf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #10 clk = ~clk;

  uart_buffer_arbiter #(.N(N), .MAX_ADDRESS(MAX_ADDRESS), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_req    (wr_req),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .rd_req    (rd_req),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .full      (full),
    .empty     (empty),
    .count     (count)
`ifdef UART_BUF_ERR_FLAGS_EN
    ,
    .err_clr   (err_clr),
    .ovf       (ovf),
    .udf       (udf)
`endif
  );

  // Behavioural single-port RAM, read data one cycle after the address.
  logic [W-1:0] mem [0:D-1];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // Buffer contents are a queue; pointers are integers modulo D. A granted
  // write completes 1 edge after the grant, a granted read 2 edges after it,
  // and the arbiter samples requests again on the edge after completion.
  logic [W-1:0] q[$];
  int           m_count, m_wp, m_rp, m_op, m_left;
  bit           m_last_rd, mw_ok, mr_ok, m_ovf, m_udf;
  logic         m_we, m_ack, m_valid;
  logic [N-1:0] m_addr;
  logic [W-1:0] m_wdata, m_rdata;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_count = 0; m_wp = 0; m_rp = 0; m_op = 0; m_left = 0;
      m_last_rd = 1'b1; m_ovf = 1'b0; m_udf = 1'b0;
      m_we = 1'b0; m_ack = 1'b0; m_valid = 1'b0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else begin
      m_ack = 1'b0;
      m_valid = 1'b0;
      if (m_op != 0) begin
        m_left--;
        if (m_left == 0) begin
          if (m_op == 1) begin
            q.push_back(m_wdata);
            m_count++;
            m_wp = (m_wp + 1) % D;
            m_we = 1'b0;
            m_ack = 1'b1;
          end else begin
            m_rdata = q.pop_front();
            m_count--;
            m_rp = (m_rp + 1) % D;
            m_valid = 1'b1;
          end
          m_op = 0;
        end
      end else begin
        mw_ok = wr_req && (m_count < D);
        mr_ok = rd_req && (m_count > 0);
        if (mw_ok && (!mr_ok || m_last_rd)) begin
          m_op = 1; m_left = 1; m_we = 1'b1;
          m_addr = N'(m_wp); m_wdata = wr_data; m_last_rd = 1'b0;
        end else if (mr_ok) begin
          m_op = 2; m_left = 2;
          m_addr = N'(m_rp); m_last_rd = 1'b1;
        end
        if (wr_req && m_count == D) m_ovf = 1'b1;
        if (rd_req && m_count == 0) m_udf = 1'b1;
      end
      if (err_clr) begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (rst) begin
      check("count", count, m_count);
      check("full", full, (m_count == D));
      check("empty", empty, (m_count == 0));
      check("wr_ack", wr_ack, m_ack);
      check("rd_valid", rd_valid, m_valid);
      check("ram_we", ram_we, m_we);
      check("ram_addr", ram_addr, m_addr);
      check("rd_data", rd_data, m_rdata);
      if (m_we) check("ram_wdata", ram_wdata, m_wdata);
`ifdef UART_BUF_ERR_FLAGS_EN
      check("ovf", ovf, m_ovf);
      check("udf", udf, m_udf);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_write(input logic [W-1:0] d, output logic [N-1:0] a, output int lat);
    bit got = 1'b0;
    a = '0; lat = 0;
    @(negedge clk); #1; wr_data = d; wr_req = 1'b1;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      if (ram_we) a = ram_addr;
      if (wr_ack) begin got = 1'b1; lat = k; end
    end
    #1 wr_req = 1'b0;
    check("wr_ack_seen", got, 1);
  endtask

  task automatic do_read(output logic [W-1:0] d, output logic [N-1:0] a, output int lat);
    bit got = 1'b0;
    d = '0; a = '0; lat = 0;
    @(negedge clk); #1 rd_req = 1'b1;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      if (rd_valid) begin got = 1'b1; d = rd_data; a = ram_addr; lat = k; end
    end
    #1 rd_req = 1'b0;
    check("rd_valid_seen", got, 1);
  endtask

  initial begin
    #1ms;
    n_fail++;
    $display("FAIL watchdog: actual timeout required finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  logic [N-1:0] a;
  logic [W-1:0] d;
  int           lat, nev, sig, cmin, cmax;
  bit           seen, upd_w;
  int           wp_pct, rp_pct;

  initial begin
    wr_req = 1'b0; rd_req = 1'b0; wr_data = '0; err_clr = 1'b0;
    rst = 1'b1;
    #5 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_rd_data", rd_data, 0);
    #1 rst = 1'b1;

    // Reset mid-run, then first write lands at address 0.
    do_write(8'hB1, a, lat);
    do_write(8'hB2, a, lat);
    @(negedge clk); #1 rst = 1'b0;
    #1;
    check("midrst_count", count, 0);
    check("midrst_empty", empty, 1);
    check("midrst_full", full, 0);
    check("midrst_we", ram_we, 0);
    check("midrst_pulses", {wr_ack, rd_valid}, 0);
    @(negedge clk); #1 rst = 1'b1;

    // Fill.
    for (int i = 0; i < 4; i++) begin
      do_write(8'hA1 + 8'(i), a, lat);
      check("fill_addr", a, i);
      check("wr_latency", lat, 2);
    end
    @(negedge clk);
    check("fill_count", count, 4);
    check("fill_full", full, 1);
    #1; wr_data = 8'hA5; wr_req = 1'b1; seen = 1'b0;
    repeat (10) begin @(negedge clk); if (wr_ack) seen = 1'b1; end
    check("full_no_ack", seen, 0);
    check("full_count_held", count, 4);
`ifdef UART_BUF_ERR_FLAGS_EN
    check("ovf_set", ovf, 1);
`endif
    #1 wr_req = 1'b0;
`ifdef UART_BUF_ERR_FLAGS_EN
    err_clr = 1'b1; @(negedge clk); #1 err_clr = 1'b0;
    check("ovf_clr", ovf, 0);
`endif

    // Drain.
    for (int i = 0; i < 4; i++) begin
      do_read(d, a, lat);
      check("drain_data", d, 8'hA1 + 8'(i));
      check("drain_addr", a, i);
      check("rd_latency", lat, 3);
    end
    @(negedge clk);
    check("drain_count", count, 0);
    check("drain_empty", empty, 1);
    #1 rd_req = 1'b1; seen = 1'b0;
    repeat (10) begin @(negedge clk); if (rd_valid) seen = 1'b1; end
    check("empty_no_valid", seen, 0);
`ifdef UART_BUF_ERR_FLAGS_EN
    check("udf_set", udf, 1);
`endif
    #1 rd_req = 1'b0;
`ifdef UART_BUF_ERR_FLAGS_EN
    err_clr = 1'b1; @(negedge clk); #1 err_clr = 1'b0;
    check("udf_clr", udf, 0);
`endif

    // Wrap: interleaved writes and reads cross address 3 -> 0.
    for (int i = 0; i < 6; i++) begin
      do_write(8'hC0 + 8'(i), a, lat);
      check("wrap_wr_addr", a, i % 4);
      do_read(d, a, lat);
      check("wrap_rd_addr", a, i % 4);
      check("wrap_data", d, 8'hC0 + 8'(i));
    end
    @(negedge clk);
    check("wrap_count", count, 0);

    // Tie: last grant is a read, count = 2, both sides held high.
    do_write(8'hD0, a, lat);
    do_write(8'hD1, a, lat);
    do_write(8'hD2, a, lat);
    do_read(d, a, lat);
    check("tie_setup_data", d, 8'hD0);
    @(negedge clk);
    check("tie_setup_count", count, 2);
    #1; wr_data = 8'hE0; wr_req = 1'b1; rd_req = 1'b1;
    nev = 0; sig = 0; cmin = 99; cmax = 0;
    for (int k = 0; k < 40 && nev < 4; k++) begin
      @(negedge clk);
      upd_w = 1'b0;
      if (int'(count) < cmin) cmin = int'(count);
      if (int'(count) > cmax) cmax = int'(count);
      if (wr_ack) begin sig = sig * 4 + 1; nev++; upd_w = 1'b1; end
      if (rd_valid) begin sig = sig * 4 + 2; nev++; end
      #1;
      if (nev >= 4) begin wr_req = 1'b0; rd_req = 1'b0; end
      else if (upd_w) wr_data = wr_data + 8'd1;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    check("tie_events", nev, 4);
    check("tie_order_WRWR", sig, 32'h66);
    check("tie_count_range", (cmin >= 1 && cmax <= 3), 1);
    @(negedge clk);
    check("tie_final_count", count, 2);

    // Abort: reset asserted while a read is in flight.
    #1 rd_req = 1'b1;
    @(posedge clk); #3 rst = 1'b0;
    #1;
    check("abort_count", count, 0);
    check("abort_empty", empty, 1);
    check("abort_no_valid", rd_valid, 0);
    rd_req = 1'b0; seen = 1'b0;
    repeat (3) begin @(negedge clk); if (rd_valid) seen = 1'b1; end
    #1 rst = 1'b1;
    repeat (4) begin @(negedge clk); if (rd_valid) seen = 1'b1; end
    check("abort_valid_never", seen, 0);
    do_write(8'h5A, a, lat);
    check("abort_then_addr0", a, 0);
    check("abort_then_wr_lat", lat, 2);

    // Randomised traffic with biased phases to reach full and empty.
    for (int ph = 0; ph < 3; ph++) begin
      wp_pct = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
      rp_pct = 100 - wp_pct;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk); #1;
        if (wr_req && wr_ack) wr_req = 1'b0;
        else if (!wr_req && $urandom_range(99) < wp_pct) begin
          wr_req = 1'b1; wr_data = 8'($urandom);
        end
        if (rd_req && rd_valid) rd_req = 1'b0;
        else if (!rd_req && $urandom_range(99) < rp_pct) rd_req = 1'b1;
`ifdef UART_BUF_ERR_FLAGS_EN
        err_clr = ($urandom_range(15) == 0);
`endif
      end
    end
    @(negedge clk); #1;
    wr_req = 1'b0; rd_req = 1'b0; err_clr = 1'b0;
    repeat (6) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
